pwm_multi_gen: RTL and testbench

//  Next-generation PWM engine: one prescaled up/down timebase drives CH independent PWM channels.
//  Per-channel compare values, mode and polarity are double-buffered and commit only at period boundaries.

---
 rtl/pwm_pkg.sv | 21 ++
 rtl/pwm_multi_gen_if.sv | 37 +++
 rtl/pwm_chan.sv | 62 ++++++
 rtl/pwm_multi_gen.sv | 97 +++++++++
 tb/tb_pwm_multi_gen.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_pkg
// Description : Shared constants and the per-channel function field layout.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

  localparam int FUNC_W = 3;

  localparam logic [1:0] MODE_LEFT      = 2'b00;
  localparam logic [1:0] MODE_RIGHT     = 2'b01;
  localparam logic [1:0] MODE_UNALIGNED = 2'b10;  // any mode with bit 1 set

  typedef struct packed {
    logic       invert;
    logic [1:0] mode;
  } func_t;

endpackage
`default_nettype wire

// File: rtl/pwm_multi_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : pwm_multi_gen_if
// Description : Control/status bundle between the regs block and the PWM engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface pwm_multi_gen_if #(
  parameter int CH = 4,
  parameter int CW = 16,
  parameter int PW = 8
);
  logic              en;
  logic              count_reset;
  logic              upnotdown;
  logic [PW-1:0]     prescale;
  logic [CW-1:0]     period;
  logic [CH-1:0]     pwm_en;
  logic [3*CH-1:0]   functions;
  logic [CW*CH-1:0]  compare1;
  logic [CW*CH-1:0]  compare2;
  logic [CW-1:0]     count_val;
  logic              period_evt;
  logic [CH-1:0]     pwm_out;

  modport master (
    output en, count_reset, upnotdown, prescale, period, pwm_en,
           functions, compare1, compare2,
    input  count_val, period_evt, pwm_out
  );

  modport slave (
    input  en, count_reset, upnotdown, prescale, period, pwm_en,
           functions, compare1, compare2,
    output count_val, period_evt, pwm_out
  );
endinterface
`default_nettype wire

// File: rtl/pwm_chan.sv
`default_nettype none
// ============================================================================
// Module      : pwm_chan
// Description : One PWM channel: shadowed compare/function regs, compare, output flop.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_chan
  import pwm_pkg::*;
#(
  parameter int CW = 16
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              i_load,
  input  wire logic [CW-1:0]     i_cnt,
  input  wire logic              i_en,
  input  wire logic [FUNC_W-1:0] i_func,
  input  wire logic [CW-1:0]     i_c1,
  input  wire logic [CW-1:0]     i_c2,
  output logic                   o_pwm
);

  func_t         r_func;
  logic [CW-1:0] r_c1;
  logic [CW-1:0] r_c2;
  logic          r_pwm;
  logic          w_raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_func <= '0;
      r_c1   <= '0;
      r_c2   <= '0;
    end else if (i_load) begin
      r_func <= func_t'(i_func);
      r_c1   <= i_c1;
      r_c2   <= i_c2;
    end
  end

  always_comb begin
    w_raw = 1'b0;
    if (r_func.mode[1])
      w_raw = (i_cnt >= r_c1) && (i_cnt < r_c2);
    else if (r_func.mode == MODE_RIGHT)
      w_raw = (i_cnt >= r_c1);
    else
      w_raw = (i_cnt < r_c1);
  end

  // Disable wins over invert so a disabled channel always idles low.
  always_ff @(posedge clk) begin
    if (rst)
      r_pwm <= 1'b0;
    else
      r_pwm <= i_en ? (w_raw ^ r_func.invert) : 1'b0;
  end

  assign o_pwm = r_pwm;

endmodule
`default_nettype wire

// File: rtl/pwm_multi_gen.sv
`default_nettype none
// ============================================================================
// Module      : pwm_multi_gen
// Description : Prescaled up/down timebase driving CH double-buffered PWM channels.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_multi_gen
  import pwm_pkg::*;
#(
  parameter int CH = 4,
  parameter int CW = 16,
  parameter int PW = 8
) (
  input  wire logic        clk,
  input  wire logic        rst,
  pwm_multi_gen_if.slave   bus
);

  localparam logic [CW-1:0] c_cnt_one = CW'(1);
  localparam logic [PW-1:0] c_psc_one = PW'(1);

  logic [PW-1:0] r_psc;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_period_act;
  logic          r_upnd_act;
  logic          r_evt;

  logic          w_tick;
  logic          w_wrap;
  logic          w_load;
  logic [CW-1:0] w_cnt_reload;
  logic [CH-1:0] w_pwm;

  assign w_tick       = bus.en && (r_psc == bus.prescale);
  assign w_wrap       = w_tick && (r_upnd_act ? (r_cnt == r_period_act) : (r_cnt == '0));
  assign w_load       = bus.count_reset || !bus.en || w_wrap;
  // Restart value follows the incoming direction/period, not the old active ones.
  assign w_cnt_reload = bus.upnotdown ? '0 : bus.period;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_psc        <= '0;
      r_cnt        <= '0;
      r_period_act <= '0;
      r_upnd_act   <= 1'b1;
      r_evt        <= 1'b0;
    end else if (bus.count_reset) begin
      r_psc        <= '0;
      r_cnt        <= w_cnt_reload;
      r_period_act <= bus.period;
      r_upnd_act   <= bus.upnotdown;
      r_evt        <= 1'b0;
    end else if (!bus.en) begin
      r_period_act <= bus.period;
      r_upnd_act   <= bus.upnotdown;
      r_evt        <= 1'b0;
    end else begin
      r_evt <= w_wrap;
      if (w_tick) begin
        r_psc <= '0;
        if (w_wrap) begin
          r_cnt        <= w_cnt_reload;
          r_period_act <= bus.period;
          r_upnd_act   <= bus.upnotdown;
        end else if (r_upnd_act) begin
          r_cnt <= r_cnt + c_cnt_one;
        end else begin
          r_cnt <= r_cnt - c_cnt_one;
        end
      end else begin
        r_psc <= r_psc + c_psc_one;
      end
    end
  end

  generate
    for (genvar i = 0; i < CH; i++) begin : g_chan
      pwm_chan #(.CW(CW)) u_chan (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_cnt  (r_cnt),
        .i_en   (bus.pwm_en[i]),
        .i_func (bus.functions[FUNC_W*i +: FUNC_W]),
        .i_c1   (bus.compare1[CW*i +: CW]),
        .i_c2   (bus.compare2[CW*i +: CW]),
        .o_pwm  (w_pwm[i])
      );
    end
  endgenerate

  assign bus.count_val  = r_cnt;
  assign bus.period_evt = r_evt;
  assign bus.pwm_out    = w_pwm;

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_multi_gen
// Description : Directed stimulus with cycle-stamped expectations checked by a monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_multi_gen;

  localparam int CH = 4;
  localparam int CW = 16;
  localparam int PW = 8;

  typedef struct {
    int cyc;
    int kind;   // 0 count_val, 1 period_evt, 2+i pwm_out[i]
    int val;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t q[$];

  pwm_multi_gen_if #(.CH(CH), .CW(CW), .PW(PW)) bus ();

  pwm_multi_gen #(.CH(CH), .CW(CW), .PW(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      0:       return "count_val";
      1:       return "period_evt";
      default: return $sformatf("pwm_out[%0d]", k - 2);
    endcase
  endfunction

  task automatic push(input int c, input int k, input int v);
    exp_t e;
    e.cyc  = c;
    e.kind = k;
    e.val  = v;
    q.push_back(e);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc <= cyc) begin
        int act;
        case (q[i].kind)
          0:       act = int'(bus.count_val);
          1:       act = bus.period_evt ? 1 : 0;
          default: act = bus.pwm_out[q[i].kind - 2] ? 1 : 0;
        endcase
        checks++;
        if (q[i].cyc < cyc || act != q[i].val) begin
          failures++;
          $display("FAIL %s: actual=%0d required=%0d cyc=%0d", kname(q[i].kind), act, q[i].val, q[i].cyc);
        end
        q.delete(i);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0, s, r, d;
    bus.en = 1'b0; bus.count_reset = 1'b0; bus.upnotdown = 1'b0;
    bus.prescale = '0; bus.period = '0; bus.pwm_en = '0;
    bus.functions = '0; bus.compare1 = '0; bus.compare2 = '0;

    // Reset state
    wait_cyc(2);
    for (int k = 0; k < 6; k++) push(2, k, 0);

    // Up count, period 9, ch0 left-aligned c1=3
    bus.en = 1'b1; bus.prescale = 8'd0; bus.period = 16'd9; bus.upnotdown = 1'b1;
    bus.pwm_en = 4'hF; bus.functions = '0;
    bus.compare1 = {16'd0, 16'd0, 16'd0, 16'd3}; bus.compare2 = '0;
    rst = 1'b0; bus.count_reset = 1'b1;
    t0 = cyc + 1;
    push(t0, 0, 0); push(t0, 1, 0);
    for (int k = 1; k <= 30; k++) begin
      push(t0 + k, 0, k % 10);
      push(t0 + k, 1, (k % 10 == 0) ? 1 : 0);
      push(t0 + k, 2, ((k - 1) % 10 < 3) ? 1 : 0);
      push(t0 + k, 3, 0);
    end
    wait_cyc(t0);
    bus.count_reset = 1'b0;

    // Mid-period shadow write at cnt=5: c1 3->7, period 9->19
    for (int k = 36; k <= 39; k++) begin
      push(t0 + k, 0, k % 10);
      push(t0 + k, 1, 0);
      push(t0 + k, 2, 0);
    end
    for (int j = 0; j <= 40; j++) begin
      push(t0 + 40 + j, 0, j % 20);
      push(t0 + 40 + j, 1, (j % 20 == 0) ? 1 : 0);
      push(t0 + 40 + j, 2, (j == 0) ? 0 : (((j - 1) % 20 < 7) ? 1 : 0));
    end
    wait_cyc(t0 + 35);
    bus.compare1 = {16'd0, 16'd0, 16'd0, 16'd7};
    bus.period   = 16'd19;

    // Mixed channel modes, loaded through count_reset
    wait_cyc(t0 + 82);
    s = cyc;
    bus.period    = 16'd9;
    bus.functions = {3'b010, 3'b101, 3'b010, 3'b100};
    bus.compare1  = {16'd5, 16'd8, 16'd2, 16'd0};
    bus.compare2  = {16'd5, 16'd0, 16'd6, 16'd0};
    bus.count_reset = 1'b1;
    push(s + 1, 0, 0); push(s + 1, 1, 0);
    for (int k = 1; k <= 20; k++) begin
      int c;
      c = (k - 1) % 10;
      push(s + 1 + k, 0, k % 10);
      push(s + 1 + k, 2, 1);
      push(s + 1 + k, 3, (c >= 2 && c <= 5) ? 1 : 0);
      push(s + 1 + k, 4, (c < 8) ? 1 : 0);
      push(s + 1 + k, 5, 0);
    end
    wait_cyc(s + 1);
    bus.count_reset = 1'b0;

    // Disable inverted ch0, then count_reset at cnt=6, then 5-clk freeze
    wait_cyc(s + 21);
    bus.pwm_en = 4'b1110;
    push(s + 22, 2, 0); push(s + 23, 2, 0);
    r = s + 27;
    push(r, 0, 6);
    push(r + 1, 0, 0); push(r + 1, 1, 0);
    push(r + 2, 0, 1); push(r + 3, 0, 2);
    for (int j = 4; j <= 8; j++) begin
      push(r + j, 0, 2);
      push(r + j, 1, 0);
    end
    push(r + 9, 0, 3);
    wait_cyc(r);
    bus.count_reset = 1'b1;
    wait_cyc(r + 1);
    bus.count_reset = 1'b0;
    wait_cyc(r + 3);
    bus.en = 1'b0;
    wait_cyc(r + 8);
    bus.en = 1'b1;

    // Down count, prescale 3, period 4
    wait_cyc(r + 10);
    d = cyc;
    bus.upnotdown = 1'b0; bus.prescale = 8'd3; bus.period = 16'd4;
    bus.count_reset = 1'b1;
    for (int m = 0; m <= 45; m++) begin
      push(d + 1 + m, 0, 4 - ((m / 4) % 5));
      push(d + 1 + m, 1, (m > 0 && m % 20 == 0) ? 1 : 0);
    end
    // Mid-period reset, then restart from zeroed active regs
    for (int k = 0; k < 6; k++) push(d + 47, k, 0);
    for (int j = 48; j <= 50; j++) begin
      push(d + j, 0, 0);
      push(d + j, 1, 0);
    end
    for (int k = 2; k < 6; k++) push(d + 48, k, 0);
    push(d + 51, 0, 4); push(d + 51, 1, 1);
    push(d + 52, 0, 4); push(d + 52, 1, 0);
    wait_cyc(d + 1);
    bus.count_reset = 1'b0;
    wait_cyc(d + 46);
    rst = 1'b1;
    wait_cyc(d + 47);
    rst = 1'b0;

    wait_cyc(d + 56);
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL pending: actual=%0d required=0 unchecked expectations", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
